// File: rtl/matrix_calculator_mem_arbiter_if.sv
// Requester-side bus for the shared on-chip memory arbiter.
// The requester uses the master modport and the arbiter uses the slave modport.
interface matrix_calculator_mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              err;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid, err
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid, err
  );
endinterface

// File: rtl/matrix_calculator_mem_arbiter.sv
// Round-robin arbiter sharing the single-port on-chip memory between the host
// (m0) and the matrix engine (m1), with out-of-range blocking and a conflict counter.
module matrix_calculator_mem_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int BE_W      = DATA_W / 8,
  parameter int NUM_WORDS = 10024
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_calculator_mem_arbiter_if.slave m0,
  matrix_calculator_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [BE_W-1:0]      mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_writedata,
  output logic                 mem_clken,
  input  logic [DATA_W-1:0]    mem_readdata,
  output logic [15:0]          conflict_count
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_WORDS);

  logic              req0, req1;
  logic              grant0, grant1, accepted;
  logic              last_grant;
  logic [ADDR_W-1:0] sel_address;
  logic              sel_write;
  logic              in_range;
  logic              rd_vld, rd_owner, rd_oor;
  logic              err0, err1;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || last_grant)) grant0 = 1'b1;
      else if (req1)                     grant1 = 1'b1;
    end
  end

  assign accepted = grant0 | grant1;

  // With no grant the memory-side fields simply follow requester 0.
  assign sel_address    = grant1 ? m1.address    : m0.address;
  assign sel_write      = grant1 ? m1.write      : m0.write;
  assign mem_address    = sel_address;
  assign mem_byteenable = grant1 ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = grant1 ? m1.writedata  : m0.writedata;

  assign in_range       = {1'b0, sel_address} < LIMIT;
  assign mem_chipselect = accepted & in_range;
  assign mem_write      = mem_chipselect & sel_write;
  assign mem_clken      = 1'b1;

  assign m0.waitrequest = ~grant0;
  assign m1.waitrequest = ~grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant     <= 1'b1;
      rd_vld         <= 1'b0;
      rd_owner       <= 1'b0;
      rd_oor         <= 1'b0;
      err0           <= 1'b0;
      err1           <= 1'b0;
      conflict_count <= '0;
    end else begin
      if (accepted) last_grant <= grant1;
      rd_vld   <= accepted & ~sel_write;
      rd_owner <= grant1;
      rd_oor   <= ~in_range;
      err0     <= grant0 & ~in_range;
      err1     <= grant1 & ~in_range;
      if (req0 && req1 && conflict_count != '1)
        conflict_count <= conflict_count + 16'd1;
    end
  end

  // Returns are masked during reset so a read in flight never reports back.
  assign m0.readdatavalid = rd_vld & ~rd_owner & ~reset;
  assign m1.readdatavalid = rd_vld &  rd_owner & ~reset;
  assign m0.readdata      = (m0.readdatavalid && !rd_oor) ? mem_readdata : '0;
  assign m1.readdata      = (m1.readdatavalid && !rd_oor) ? mem_readdata : '0;
  assign m0.err           = err0 & ~reset;
  assign m1.err           = err1 & ~reset;
endmodule

// File: tb/tb_matrix_calculator_mem_arbiter.sv
// Directed bench for matrix_calculator_mem_arbiter with a behavioural
// 1-cycle-latency byte-enabled memory behind the arbiter.
module tb_matrix_calculator_mem_arbiter;
  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BE_W      = 4;
  localparam int NUM_WORDS = 10024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  matrix_calculator_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_bus ();
  matrix_calculator_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_bus ();

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [15:0]       conflict_count;

  matrix_calculator_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .NUM_WORDS(NUM_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .m0(m0_bus), .m1(m1_bus),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .conflict_count(conflict_count)
  );

  logic [31:0] mem [0:NUM_WORDS-1];

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken && int'(mem_address) < NUM_WORDS) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_bus.read = 1'b0; m0_bus.write = 1'b0;
    m1_bus.read = 1'b0; m1_bus.write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    m0_bus.address = '0; m0_bus.byteenable = '0; m0_bus.writedata = '0;
    m1_bus.address = '0; m1_bus.byteenable = '0; m1_bus.writedata = '0;
    for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    mem[5]       <= 32'hDEADBEEF;
    mem[100]     <= 32'hAABBCCDD;
    mem_readdata <= '0;

    // Reset with a pending request: nothing granted.
    reset = 1'b1; m0_bus.read = 1'b1; m0_bus.address = 14'd5;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wait0", m0_bus.waitrequest, 1);
    check("rst_wait1", m1_bus.waitrequest, 1);
    check("rst_cs", mem_chipselect, 0);
    check("rst_rdv0", m0_bus.readdatavalid, 0);
    check("rst_rdv1", m1_bus.readdatavalid, 0);
    check("rst_err0", m0_bus.err, 0);
    check("rst_cnt", conflict_count, 0);

    // Single read, granted in the release cycle.
    @(negedge clk); reset = 1'b0; #1;
    check("sr_wait0", m0_bus.waitrequest, 0);
    check("sr_wait1", m1_bus.waitrequest, 1);
    check("sr_cs", mem_chipselect, 1);
    check("sr_addr", mem_address, 5);
    check("sr_memwr", mem_write, 0);
    @(negedge clk);
    check("sr_rdv0", m0_bus.readdatavalid, 1);
    check("sr_data0", m0_bus.readdata, 32'hDEADBEEF);
    check("sr_rdv1", m1_bus.readdatavalid, 0);
    idle();

    // No grant: memory fields follow requester 0.
    m0_bus.address = 14'd7; m1_bus.address = 14'd9; #1;
    check("ng_cs", mem_chipselect, 0);
    check("ng_wr", mem_write, 0);
    check("ng_addr", mem_address, 7);
    check("ng_wait0", m0_bus.waitrequest, 1);
    check("ng_wait1", m1_bus.waitrequest, 1);

    // Tie-break and strict alternation from a fresh reset.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    m0_bus.read = 1'b1; m0_bus.address = 14'd5;
    m1_bus.read = 1'b1; m1_bus.address = 14'd100;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("tie_wait0", m0_bus.waitrequest, (i % 2) == 1);
      check("tie_wait1", m1_bus.waitrequest, (i % 2) == 0);
      @(negedge clk);
      check("tie_rdv0", m0_bus.readdatavalid, (i % 2) == 0);
      check("tie_rdv1", m1_bus.readdatavalid, (i % 2) == 1);
      check("tie_data0", m0_bus.readdata, (i % 2) == 0 ? 32'hDEADBEEF : 32'h0);
      check("tie_data1", m1_bus.readdata, (i % 2) == 1 ? 32'hAABBCCDD : 32'h0);
    end
    idle();
    check("tie_cnt", conflict_count, 6);

    // Byte-enabled write then read-back.
    m1_bus.write = 1'b1; m1_bus.address = 14'd100;
    m1_bus.writedata = 32'h11223344; m1_bus.byteenable = 4'b0101; #1;
    check("bw_wait1", m1_bus.waitrequest, 0);
    check("bw_cs", mem_chipselect, 1);
    check("bw_memwr", mem_write, 1);
    check("bw_be", mem_byteenable, 4'b0101);
    check("bw_wdata", mem_writedata, 32'h11223344);
    @(negedge clk);
    check("bw_rdv1", m1_bus.readdatavalid, 0);
    m1_bus.write = 1'b0; m1_bus.read = 1'b1; #1;
    check("br_wait1", m1_bus.waitrequest, 0);
    check("br_memwr", mem_write, 0);
    @(negedge clk);
    check("br_rdv1", m1_bus.readdatavalid, 1);
    check("br_data1", m1_bus.readdata, 32'hAA22CC44);
    check("br_rdv0", m0_bus.readdatavalid, 0);
    idle();

    // Highest valid address is in range.
    m0_bus.read = 1'b1; m0_bus.address = 14'd10023; #1;
    check("hi_cs", mem_chipselect, 1);
    @(negedge clk);
    check("hi_rdv0", m0_bus.readdatavalid, 1);
    check("hi_err0", m0_bus.err, 0);
    idle();

    // Read and write together behave as a write.
    m0_bus.read = 1'b1; m0_bus.write = 1'b1; m0_bus.address = 14'd6;
    m0_bus.writedata = 32'h12345678; m0_bus.byteenable = 4'hF; #1;
    check("rw_memwr", mem_write, 1);
    @(negedge clk);
    check("rw_rdv0", m0_bus.readdatavalid, 0);
    m0_bus.write = 1'b0;
    @(negedge clk);
    check("rw_data0", m0_bus.readdata, 32'h12345678);
    idle();

    // Out-of-range write then read.
    m0_bus.write = 1'b1; m0_bus.address = 14'd10024;
    m0_bus.writedata = 32'hFFFFFFFF; m0_bus.byteenable = 4'hF; #1;
    check("oow_wait0", m0_bus.waitrequest, 0);
    check("oow_cs", mem_chipselect, 0);
    check("oow_memwr", mem_write, 0);
    @(negedge clk);
    check("oow_err0", m0_bus.err, 1);
    check("oow_err1", m1_bus.err, 0);
    check("oow_rdv0", m0_bus.readdatavalid, 0);
    m0_bus.write = 1'b0; m0_bus.read = 1'b1; m0_bus.address = 14'd16383; #1;
    check("oor_cs", mem_chipselect, 0);
    check("oor_wait0", m0_bus.waitrequest, 0);
    @(negedge clk);
    check("oor_err0", m0_bus.err, 1);
    check("oor_rdv0", m0_bus.readdatavalid, 1);
    check("oor_data0", m0_bus.readdata, 0);
    idle();
    @(negedge clk);
    check("oor_err0_end", m0_bus.err, 0);
    check("oor_rdv0_end", m0_bus.readdatavalid, 0);
    check("oor_mem5", mem[5], 32'hDEADBEEF);
    check("oor_mem6", mem[6], 32'h12345678);

    // Reset while a read is in flight.
    m1_bus.read = 1'b1; m1_bus.address = 14'd100; #1;
    check("mr_wait1", m1_bus.waitrequest, 0);
    @(negedge clk); reset = 1'b1; idle(); #1;
    check("mr_rdv1", m1_bus.readdatavalid, 0);
    @(negedge clk);
    check("mr_rdv1_after", m1_bus.readdatavalid, 0);
    check("mr_cnt", conflict_count, 0);
    reset = 1'b0; m0_bus.read = 1'b1; m1_bus.read = 1'b1; #1;
    check("mr_tie_wait0", m0_bus.waitrequest, 0);
    check("mr_tie_wait1", m1_bus.waitrequest, 1);
    // m0 just won; reset must still restore m0 priority on the next tie.
    @(negedge clk); reset = 1'b1; #1;
    check("mr_hold_wait0", m0_bus.waitrequest, 1);
    check("mr_hold_wait1", m1_bus.waitrequest, 1);
    @(negedge clk); reset = 1'b0; #1;
    check("mr_tie2_wait0", m0_bus.waitrequest, 0);
    check("mr_tie2_wait1", m1_bus.waitrequest, 1);

    // Conflict counter saturation.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (65534) @(negedge clk);
    check("sat_fffe", conflict_count, 16'hFFFE);
    repeat (10) @(negedge clk);
    check("sat_ffff", conflict_count, 16'hFFFF);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
